// File: rtl/ysyx22041405_exu_pipe.sv
// ---------------------------------------------------------------------------
// ysyx22041405_exu_pipe
// Handshaked execute stage. It accepts decoded operations from ID over a
// valid/ready channel and executes single-cycle ALU ops. It optionally runs
// iterative multiply/divide ops. Results are held in an output register and
// handed to MEM/WB over a second valid/ready channel.
//
// Configuration macro: EXU_MDU_EN
//   defined   - ops 10..15 run on the shift-add / restoring-divide unit.
//   undefined - no MDU; ops 10..15 complete in one cycle as illegal
//               (result 0, we 0, illegal 1) and busy is tied to 0.
//
// Ports:
//   clk, rst (async, active-low), flush (sync kill of held/in-flight work)
//   in_valid/in_ready, in_op, in_src1, in_src2, in_rd, in_we, in_pc : from ID
//   out_valid/out_ready, out_result, out_rd, out_we, out_pc,
//   out_illegal                                                     : to MEM/WB
//   busy : MDU iterating
// ---------------------------------------------------------------------------
module ysyx22041405_exu_pipe #(
   parameter int WIDTH = 32,
   parameter int RF_AW = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       in_op,
   input  logic [WIDTH-1:0] in_src1,
   input  logic [WIDTH-1:0] in_src2,
   input  logic [RF_AW-1:0] in_rd,
   input  logic             in_we,
   input  logic [WIDTH-1:0] in_pc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic [RF_AW-1:0] out_rd,
   output logic             out_we,
   output logic [WIDTH-1:0] out_pc,
   output logic             out_illegal,
   output logic             busy
);

   localparam int SW = $clog2(WIDTH);

   localparam logic [3:0] OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_SLL  = 4'd2,
                          OP_SLT  = 4'd3,  OP_SLTU = 4'd4,  OP_XOR  = 4'd5,
                          OP_SRL  = 4'd6,  OP_SRA  = 4'd7,  OP_OR   = 4'd8,
                          OP_AND  = 4'd9,  OP_MUL  = 4'd10, OP_MULHU = 4'd11,
                          OP_DIV  = 4'd12, OP_DIVU = 4'd13, OP_REM  = 4'd14;

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_HOLD = 2'd2} state_t;

   state_t           state, state_nxt;
   logic             accept;
   logic             hi_op;       // op codes 10..15
   logic             mdu_op;
   logic             illegal_op;
   logic [SW-1:0]    shamt;
   logic [WIDTH-1:0] alu_res;

   assign hi_op  = in_op[3] && (in_op[2] || in_op[1]);
   assign accept = in_valid && in_ready;
   assign shamt  = in_src2[SW-1:0];

`ifdef EXU_MDU_EN
   assign mdu_op     = hi_op;
   assign illegal_op = 1'b0;
`else
   assign mdu_op     = 1'b0;
   assign illegal_op = hi_op;
`endif

   // ---------------- FSM: state register ----------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

`ifdef EXU_MDU_EN
   logic             last;
`endif

   // ---------------- FSM: next state ----------------
   // NOTE: every always_comb output gets a default first so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (accept) state_nxt = mdu_op ? S_BUSY : S_HOLD;
`ifdef EXU_MDU_EN
         S_BUSY: if (last) state_nxt = S_HOLD;
`endif
         S_HOLD: if (out_ready) state_nxt = accept ? (mdu_op ? S_BUSY : S_HOLD) : S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
      // flush beats everything, including a same-cycle consume
      if (flush) state_nxt = S_IDLE;
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      in_ready  = rst && (state == S_IDLE || (state == S_HOLD && out_ready)) && !flush;
      out_valid = (state == S_HOLD);
`ifdef EXU_MDU_EN
      busy      = (state == S_BUSY);
`else
      busy      = 1'b0;
`endif
   end

   // ---------------- single-cycle ALU ----------------
   always_comb begin
      alu_res = '0;
      case (in_op)
         OP_ADD:  alu_res = in_src1 + in_src2;
         OP_SUB:  alu_res = in_src1 - in_src2;
         OP_SLL:  alu_res = in_src1 << shamt;
         OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(in_src1) < $signed(in_src2)};
         OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, in_src1 < in_src2};
         OP_XOR:  alu_res = in_src1 ^ in_src2;
         OP_SRL:  alu_res = in_src1 >> shamt;
         OP_SRA:  alu_res = WIDTH'($signed(in_src1) >>> shamt);
         OP_OR:   alu_res = in_src1 | in_src2;
         OP_AND:  alu_res = in_src1 & in_src2;
         default: alu_res = '0;   // 10..15: MDU result or illegal zero
      endcase
   end

`ifdef EXU_MDU_EN
   // ---------------- iterative multiply / divide ----------------
   // md_hi:md_lo is the product accumulator (mul) or remainder:quotient (div).
   // WIDTH iterations, then one extra cycle (cnt == WIDTH) for sign fix-up.
   logic [SW:0]      cnt;
   logic [3:0]       md_op;
   logic [WIDTH-1:0] md_a, md_hi, md_lo;
   logic             neg_q, neg_r, div_zero;
   logic             sgn_op, s1_neg, s2_neg;
   logic [WIDTH-1:0] mag1, mag2;
   logic [WIDTH:0]   sum, shifted, diff;
   logic [WIDTH-1:0] iter_hi, iter_lo, mdu_res;

   assign last   = (cnt == (SW+1)'(WIDTH));
   assign sgn_op = (in_op == OP_DIV) || (in_op == OP_REM);
   assign s1_neg = sgn_op && in_src1[WIDTH-1];
   assign s2_neg = sgn_op && in_src2[WIDTH-1];
   assign mag1   = s1_neg ? -in_src1 : in_src1;
   assign mag2   = s2_neg ? -in_src2 : in_src2;

   always_comb begin
      sum     = {1'b0, md_hi} + (md_lo[0] ? {1'b0, md_a} : '0);
      shifted = {md_hi, md_lo[WIDTH-1]};
      diff    = shifted - {1'b0, md_a};   // diff[WIDTH] set => borrow, restore
      if (!md_op[2]) begin
         iter_hi = sum[WIDTH:1];
         iter_lo = {sum[0], md_lo[WIDTH-1:1]};
      end else begin
         iter_hi = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
         iter_lo = {md_lo[WIDTH-2:0], ~diff[WIDTH]};
      end
   end

   // Overflow (-2^(W-1) / -1) needs no special case: magnitude quotient is
   // 2^(W-1), signs agree, so no negation and the remainder is 0.
   always_comb begin
      mdu_res = '0;
      case (md_op)
         OP_MUL:           mdu_res = md_lo;
         OP_MULHU:         mdu_res = md_hi;
         OP_DIV, OP_DIVU:  mdu_res = div_zero ? '1 : (neg_q ? -md_lo : md_lo);
         default:          mdu_res = neg_r ? -md_hi : md_hi;
      endcase
   end
`endif

   // ---------------- result / datapath registers ----------------
   // NOTE: these are a handful of flops, not a memory, so they are reset to
   // give the all-zero output values visible while rst is low.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_result  <= '0;
         out_rd      <= '0;
         out_we      <= 1'b0;
         out_pc      <= '0;
         out_illegal <= 1'b0;
`ifdef EXU_MDU_EN
         cnt <= '0;  md_op <= '0;  md_a <= '0;  md_hi <= '0;  md_lo <= '0;
         neg_q <= 1'b0;  neg_r <= 1'b0;  div_zero <= 1'b0;
`endif
      end else if (accept) begin
         out_result  <= alu_res;
         out_rd      <= in_rd;
         out_we      <= in_we && !illegal_op;
         out_pc      <= in_pc;
         out_illegal <= illegal_op;
`ifdef EXU_MDU_EN
         cnt      <= '0;
         md_op    <= in_op;
         md_hi    <= '0;
         md_lo    <= in_op[2] ? mag1 : in_src1;
         md_a     <= in_op[2] ? mag2 : in_src2;
         neg_q    <= s1_neg ^ s2_neg;
         neg_r    <= s1_neg;
         div_zero <= (in_src2 == '0);
`endif
      end
`ifdef EXU_MDU_EN
      else if (state == S_BUSY) begin
         if (last) begin
            out_result <= mdu_res;
         end else begin
            md_hi <= iter_hi;
            md_lo <= iter_lo;
            cnt   <= cnt + 1'b1;
         end
      end
`endif
   end

endmodule
